// File: rtl/pc_fetch.sv
// pc_fetch: single-outstanding instruction fetch unit.
// Issues one request per instruction, buffers the returned word for decode and
// handles redirects, including dropping a response that belongs to an abandoned
// fetch. Define FETCH_ALIGN_CHECK_EN to trap misaligned PCs in a FAULT state;
// without it, fault is tied low and the low two PC bits are masked off the address.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] pc,
  input  logic        ins_ready,
  output logic        fault
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic        ins_valid_q, ins_valid_d;
  // Set while the response of an abandoned fetch is still owed by memory.
  logic        discard_q, discard_d;

  // Next-state logic: request, wait for the response, hold it until decode takes it.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    discard_d   = discard_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // A request granted in the redirect cycle still returns data; it must be dropped.
          if (imem_gnt) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (redirect) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else if (discard_q) begin
            state_d = S_REQ;
          end else begin
            ins_d       = imem_rdata;
            ins_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end else if (redirect) begin
          // Keep waiting for the in-flight response so it can be thrown away.
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect wins over a same-cycle consume; next_pc is ignored then.
        if (redirect) begin
          pc_d        = redirect_pc;
          ins_valid_d = 1'b0;
          state_d     = S_REQ;
        end else if (ins_ready) begin
          pc_d        = next_pc;
          ins_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_FAULT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    // Any PC that ends up misaligned parks the unit in FAULT; an outstanding
    // response is then simply ignored there.
    if (pc_d[1:0] != 2'b00) begin
      state_d     = S_FAULT;
      ins_valid_d = 1'b0;
      discard_d   = 1'b0;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      ins_q       <= 32'h0;
      ins_valid_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      discard_q   <= discard_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign ins_valid = ins_valid_q;
  assign ins       = ins_q;
  assign pc        = pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign imem_addr = pc_q;
  assign fault     = (state_q == S_FAULT);
`else
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: table-driven, directed and randomized bench for pc_fetch.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ins_ready;
  logic        fault;

  pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .pc          (pc),
    .ins_ready   (ins_ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: a fetch is either being requested, in flight,
  // or sitting in the buffer; in-flight fetches may be marked as unwanted.
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic        m_has_ins;
  logic        m_in_flight;
  logic        m_unwanted;

  task automatic model_reset();
    m_pc        = 32'h0000_3000;
    m_ins       = 32'h0;
    m_has_ins   = 1'b0;
    m_in_flight = 1'b0;
    m_unwanted  = 1'b0;
  endtask

  task automatic model_step(input logic rd, input logic [31:0] rpc, input logic gnt,
                            input logic rv, input logic [31:0] rdat, input logic rdy,
                            input logic [31:0] npc);
    if (m_has_ins) begin
      if (rd) begin
        m_pc = rpc; m_has_ins = 1'b0;
      end else if (rdy) begin
        m_pc = npc; m_has_ins = 1'b0;
      end
    end else if (m_in_flight) begin
      if (rv) begin
        m_in_flight = 1'b0;
        if (!rd && !m_unwanted) begin
          m_has_ins = 1'b1; m_ins = rdat;
        end
        m_unwanted = 1'b0;
        if (rd) m_pc = rpc;
      end else if (rd) begin
        m_pc = rpc; m_unwanted = 1'b1;
      end
    end else begin
      if (rd) begin
        m_pc = rpc;
        if (gnt) begin
          m_in_flight = 1'b1; m_unwanted = 1'b1;
        end
      end else if (gnt) begin
        m_in_flight = 1'b1;
      end
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic co(input string tag, input logic e_req, input logic [31:0] e_addr,
                    input logic e_iv, input logic [31:0] e_ins, input logic [31:0] e_pc);
    chk1 ({tag, ".req"},   imem_req,  e_req);
    chk32({tag, ".addr"},  imem_addr, e_addr);
    chk1 ({tag, ".valid"}, ins_valid, e_iv);
    chk32({tag, ".ins"},   ins,       e_ins);
    chk32({tag, ".pc"},    pc,        e_pc);
    chk1 ({tag, ".fault"}, fault,     1'b0);
  endtask

  // Drive one cycle of inputs at a falling edge; return at the next falling edge.
  task automatic apply(input logic rd, input logic [31:0] rpc, input logic gnt,
                       input logic rv, input logic [31:0] rdat, input logic rdy,
                       input logic [31:0] npc);
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    ins_ready   = rdy;
    next_pc     = npc;
    model_step(rd, rpc, gnt, rv, rdat, rdy, npc);
    @(negedge clk);
  endtask

  // Assert reset between clock edges and check it took effect without a clock.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    co("reset", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r_rd, r_gnt, r_rv, r_rdy;
    logic [31:0] r_rpc, r_rdata, r_npc, wrap_pc;

    // Zero-wait memory, decode always ready: one instruction every third cycle.
    tbl[0] = '{1'b1, 1'b1, 32'hAAAA_0000, 1'b1, 32'h3004, 1'b0, 32'h3000, 1'b0, 32'h0000_0000, 32'h3000};
    tbl[1] = '{1'b1, 1'b1, 32'hA000_0001, 1'b1, 32'h3004, 1'b0, 32'h3000, 1'b1, 32'hA000_0001, 32'h3000};
    tbl[2] = '{1'b1, 1'b1, 32'hBAD0_0002, 1'b1, 32'h3004, 1'b1, 32'h3004, 1'b0, 32'hA000_0001, 32'h3004};
    tbl[3] = '{1'b1, 1'b1, 32'hBAD0_0003, 1'b1, 32'h3008, 1'b0, 32'h3004, 1'b0, 32'hA000_0001, 32'h3004};
    tbl[4] = '{1'b1, 1'b1, 32'hA000_0004, 1'b1, 32'h3008, 1'b0, 32'h3004, 1'b1, 32'hA000_0004, 32'h3004};
    tbl[5] = '{1'b1, 1'b1, 32'hBAD0_0005, 1'b1, 32'h3008, 1'b1, 32'h3008, 1'b0, 32'hA000_0004, 32'h3008};
    tbl[6] = '{1'b1, 1'b1, 32'hBAD0_0006, 1'b1, 32'h300C, 1'b0, 32'h3008, 1'b0, 32'hA000_0004, 32'h3008};
    tbl[7] = '{1'b1, 1'b1, 32'hA000_0007, 1'b1, 32'h300C, 1'b0, 32'h3008, 1'b1, 32'hA000_0007, 32'h3008};
    tbl[8] = '{1'b1, 1'b1, 32'hBAD0_0008, 1'b1, 32'h300C, 1'b1, 32'h300C, 1'b0, 32'hA000_0007, 32'h300C};

    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; ins_ready = 1'b0; next_pc = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();
    co("release", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000);

    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 32'h0, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].npc);
      co($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_ins, tbl[i].e_pc);
    end

    // Memory stalls the grant: request and address must stay put.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      co($sformatf("stall%0d", i), 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000);
    end
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("stall_gnt", 1'b0, 32'h3000, 1'b0, 32'h0, 32'h3000);

    // Decode back-pressure: buffered instruction must hold, no new request.
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    co("bp_fill", 1'b0, 32'h3000, 1'b1, 32'h1111_1111, 32'h3000);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 32'h0, 1'b1, 1'b1, $urandom(), 1'b0, 32'h3004);
      co($sformatf("bp_hold%0d", i), 1'b0, 32'h3000, 1'b1, 32'h1111_1111, 32'h3000);
    end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3004);
    co("bp_take", 1'b1, 32'h3004, 1'b0, 32'h1111_1111, 32'h3004);

    // Redirect while waiting: the following response is dropped.
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rw_gnt", 1'b0, 32'h3004, 1'b0, 32'h1111_1111, 32'h3004);
    apply(1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rw_redir", 1'b0, 32'h3100, 1'b0, 32'h1111_1111, 32'h3100);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0);
    co("rw_drop", 1'b1, 32'h3100, 1'b0, 32'h1111_1111, 32'h3100);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rw_gnt2", 1'b0, 32'h3100, 1'b0, 32'h1111_1111, 32'h3100);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0);
    co("rw_fill", 1'b0, 32'h3100, 1'b1, 32'h2222_2222, 32'h3100);

    // Redirect and consume together: redirect wins.
    apply(1'b1, 32'h3200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3004);
    co("rd_vs_rdy", 1'b1, 32'h3200, 1'b0, 32'h2222_2222, 32'h3200);

    // Redirect in the same cycle as the response.
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rv_gnt", 1'b0, 32'h3200, 1'b0, 32'h2222_2222, 32'h3200);
    apply(1'b1, 32'h3300, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0);
    co("rv_redir", 1'b1, 32'h3300, 1'b0, 32'h2222_2222, 32'h3300);

    // Redirect together with grant in REQ: that response is discarded.
    apply(1'b1, 32'h3400, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rg_redir", 1'b0, 32'h3400, 1'b0, 32'h2222_2222, 32'h3400);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h0);
    co("rg_drop", 1'b1, 32'h3400, 1'b0, 32'h2222_2222, 32'h3400);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rg_gnt", 1'b0, 32'h3400, 1'b0, 32'h2222_2222, 32'h3400);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0);
    co("rg_fill", 1'b0, 32'h3400, 1'b1, 32'h5555_5555, 32'h3400);

    // Consume, then a redirect in REQ without a grant.
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3404);
    co("rq_take", 1'b1, 32'h3404, 1'b0, 32'h5555_5555, 32'h3404);
    apply(1'b1, 32'h3500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    co("rq_redir", 1'b1, 32'h3500, 1'b0, 32'h5555_5555, 32'h3500);

    // PC wrap at the top of the address space.
    apply(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    co("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h5555_5555, 32'hFFFF_FFFC);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 32'h0);
    co("wrap_fill", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h6666_6666, 32'hFFFF_FFFC);
    wrap_pc = 32'hFFFF_FFFC + 32'd4;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, wrap_pc);
    co("wrap_take", 1'b1, 32'h0, 1'b0, 32'h6666_6666, 32'h0);

    // Stray response while requesting is ignored.
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0);
    co("stray_rv", 1'b1, 32'h0, 1'b0, 32'h6666_6666, 32'h0);

    // Reset with a fetch in flight; the late response must not be captured.
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    co("mid_gnt", 1'b0, 32'h0, 1'b0, 32'h6666_6666, 32'h0);
    do_reset();
    co("mid_release", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h9999_9999, 1'b0, 32'h0);
    co("mid_late_rv", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h3000);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    co("mid_fill", 1'b0, 32'h3000, 1'b1, 32'h1234_5678, 32'h3000);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned consume target traps; an aligned redirect recovers.
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3002);
    chk1 ("flt.fault", fault, 1'b1);
    chk1 ("flt.req", imem_req, 1'b0);
    chk1 ("flt.valid", ins_valid, 1'b0);
    chk32("flt.pc", pc, 32'h3002);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 32'h0, 1'b1, 1'b1, 32'hBADB_AD00, 1'b1, 32'h3008);
      chk1 ($sformatf("flt_stay%0d.fault", i), fault, 1'b1);
      chk1 ($sformatf("flt_stay%0d.req", i), imem_req, 1'b0);
      chk1 ($sformatf("flt_stay%0d.valid", i), ins_valid, 1'b0);
    end
    apply(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1 ("flt_exit.fault", fault, 1'b0);
    chk1 ("flt_exit.req", imem_req, 1'b1);
    chk32("flt_exit.addr", imem_addr, 32'h3000);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'hABCD_0000, 1'b0, 32'h0);
    chk1 ("flt_resume.valid", ins_valid, 1'b1);
    chk32("flt_resume.ins", ins, 32'hABCD_0000);
    chk32("flt_resume.pc", pc, 32'h3000);
`else
    // Without alignment checking the low PC bits are masked off the address.
    apply(1'b1, 32'h3102, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    co("mis_redir", 1'b1, 32'h3100, 1'b0, 32'h1234_5678, 32'h3102);
    apply(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    co("mis_back", 1'b1, 32'h3000, 1'b0, 32'h1234_5678, 32'h3000);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r_rd    = ($urandom_range(7) == 0);
      r_gnt   = ($urandom_range(1) == 1);
      r_rv    = ($urandom_range(1) == 1);
      r_rdy   = ($urandom_range(2) != 0);
      r_rpc   = $urandom() & 32'hFFFF_FFFC;
      r_rdata = $urandom();
      if ($urandom_range(3) != 0) r_npc = m_pc + 32'd4;
      else                        r_npc = $urandom() & 32'hFFFF_FFFC;
      apply(r_rd, r_rpc, r_gnt, r_rv, r_rdata, r_rdy, r_npc);
      co($sformatf("rand%0d", i), !m_has_ins && !m_in_flight, {m_pc[31:2], 2'b00},
         m_has_ins, m_ins, m_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
